// File: rtl/stack_if.sv
// stack_if: push/pop strobes, data and status bundle between control unit and stack_unit
interface stack_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 7
);
  logic              push;
  logic              pop;
  logic              hold;
  logic [DATA_W-1:0] d;
  logic [DATA_W-1:0] q;
  logic [ADDR_W:0]   sp;
  logic              empty;
  logic              full;
  logic              overflow;
  logic              underflow;
  modport master (output push, pop, hold, d, input q, sp, empty, full, overflow, underflow);
  modport slave  (input push, pop, hold, d, output q, sp, empty, full, overflow, underflow);
endinterface

// File: rtl/stack_unit.sv
// stack_unit: hardware LIFO stack with registered pop data; STACK_GUARD_EN enables full/empty protection and sticky error flags
module stack_unit #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 128,
  parameter int ADDR_W = 7
) (
  input logic    clk,
  input logic    reset,
  stack_if.slave s
);
  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [ADDR_W:0]   r_sp;
  logic [DATA_W-1:0] r_q;
  logic              r_ovf;
  logic              r_udf;
  logic              w_push_e;
  logic              w_pop_e;
  logic              w_empty;
  logic              w_full;
  logic [ADDR_W-1:0] w_low;
  logic [ADDR_W-1:0] w_top;
  logic [DATA_W-1:0] w_rd;
  logic              w_wr;
  logic [ADDR_W-1:0] w_waddr;
  logic [ADDR_W:0]   w_sp_nxt;
  logic              w_q_ld;
  logic [DATA_W-1:0] w_q_nxt;
  logic              w_ovf_set;
  logic              w_udf_set;

  assign w_push_e = s.push & ~s.hold;
  assign w_pop_e  = s.pop & ~s.hold;
  assign w_low    = r_sp[ADDR_W-1:0];
  assign w_top    = w_low - ADDR_W'(1);
  assign w_rd     = r_mem[w_top];
  assign w_empty  = r_sp == '0;
`ifdef STACK_GUARD_EN
  assign w_full   = r_sp == (ADDR_W+1)'(DEPTH);
`else
  assign w_full   = 1'b0;
`endif

  // next-state decode for pointer, read data, memory write and error flags
  always_comb begin
    w_wr      = 1'b0;
    w_waddr   = w_low;
    w_sp_nxt  = r_sp;
    w_q_ld    = 1'b0;
    w_q_nxt   = w_rd;
    w_ovf_set = 1'b0;
    w_udf_set = 1'b0;
    if (w_push_e && w_pop_e) begin
      w_q_ld  = 1'b1;
      w_q_nxt = w_empty ? s.d : w_rd;
      w_wr    = ~w_empty;
      w_waddr = w_top;
    end else if (w_push_e) begin
`ifdef STACK_GUARD_EN
      w_wr      = ~w_full;
      w_sp_nxt  = w_full ? r_sp : r_sp + (ADDR_W+1)'(1);
      w_ovf_set = w_full;
`else
      w_wr      = 1'b1;
      w_sp_nxt  = {1'b0, w_low + ADDR_W'(1)};
`endif
    end else if (w_pop_e) begin
      w_q_ld    = 1'b1;
`ifdef STACK_GUARD_EN
      w_q_nxt   = w_empty ? '0 : w_rd;
      w_sp_nxt  = w_empty ? r_sp : r_sp - (ADDR_W+1)'(1);
      w_udf_set = w_empty;
`else
      w_sp_nxt  = {1'b0, w_top};
`endif
    end
  end

  // storage array: not reset, and a write is suppressed while reset is low
  always_ff @(posedge clk) begin
    if (w_wr && reset) r_mem[w_waddr] <= s.d;
  end

  // pointer, popped data and sticky error flags
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_sp  <= '0;
      r_q   <= '0;
      r_ovf <= 1'b0;
      r_udf <= 1'b0;
    end else begin
      r_sp  <= w_sp_nxt;
      r_q   <= w_q_ld ? w_q_nxt : r_q;
      r_ovf <= r_ovf | w_ovf_set;
      r_udf <= r_udf | w_udf_set;
    end
  end

  assign s.q         = r_q;
  assign s.sp        = r_sp;
  assign s.empty     = w_empty;
  assign s.full      = w_full;
  assign s.overflow  = r_ovf;
  assign s.underflow = r_udf;
endmodule

// File: tb/tb_stack_unit.sv
// tb_stack_unit: directed and random stimulus for stack_unit checked against a LIFO reference model; honours STACK_GUARD_EN
module tb_stack_unit;
  localparam int DW = 32;
  localparam int DEPTH = 128;
  localparam int AW = 7;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int   n_pass = 0;
  int   n_total = 0;

  stack_if #(.DATA_W(DW), .ADDR_W(AW)) sif ();
  stack_unit #(.DATA_W(DW), .DEPTH(DEPTH), .ADDR_W(AW)) dut (.clk(clk), .reset(reset), .s(sif.slave));

  always #5 clk = ~clk;

  logic [DW-1:0] m_mem [DEPTH];
  int            m_sp = 0;
  logic [DW-1:0] m_q = '0;
  bit            m_ovf = 1'b0;
  bit            m_udf = 1'b0;
`ifdef STACK_GUARD_EN
  localparam bit GUARD = 1'b1;
`else
  localparam bit GUARD = 1'b0;
`endif

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  task automatic model_reset();
    m_sp = 0; m_q = '0; m_ovf = 1'b0; m_udf = 1'b0;
  endtask

  task automatic model_op(input bit pu, input bit po, input logic [DW-1:0] dv);
    if (pu && po) begin
      if (m_sp == 0) m_q = dv;
      else begin
        m_q = m_mem[m_sp-1];
        m_mem[m_sp-1] = dv;
      end
    end else if (pu) begin
      if (GUARD && m_sp == DEPTH) m_ovf = 1'b1;
      else begin
        m_mem[m_sp % DEPTH] = dv;
        m_sp = GUARD ? m_sp + 1 : (m_sp + 1) % DEPTH;
      end
    end else if (po) begin
      if (GUARD && m_sp == 0) begin
        m_q = '0;
        m_udf = 1'b1;
      end else begin
        m_sp = (m_sp + DEPTH - 1) % DEPTH;
        m_q = m_mem[m_sp];
      end
    end
  endtask

  task automatic chk_all(input string tag);
    chk({tag, ".q"}, 64'(sif.q), 64'(m_q));
    chk({tag, ".sp"}, 64'(sif.sp), 64'(m_sp));
    chk({tag, ".empty"}, 64'(sif.empty), 64'(m_sp == 0));
    chk({tag, ".full"}, 64'(sif.full), 64'(GUARD && m_sp == DEPTH));
    chk({tag, ".ovf"}, 64'(sif.overflow), 64'(m_ovf));
    chk({tag, ".udf"}, 64'(sif.underflow), 64'(m_udf));
  endtask

  task automatic step(input string tag, input bit pu, input bit po, input bit ho, input logic [DW-1:0] dv);
    @(negedge clk);
    sif.push = pu; sif.pop = po; sif.hold = ho; sif.d = dv;
    @(posedge clk);
    model_op(pu && !ho, po && !ho, dv);
    #1;
    sif.push = 1'b0; sif.pop = 1'b0; sif.hold = 1'b0;
    chk_all(tag);
  endtask

  logic [DW-1:0] v_last;

  initial begin
    sif.push = 1'b0; sif.pop = 1'b0; sif.hold = 1'b0; sif.d = '0;
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk_all("reset");

    step("push11", 1, 0, 0, 32'h11);
    step("push22", 1, 0, 0, 32'h22);
    step("push33", 1, 0, 0, 32'h33);
    step("pop1", 0, 1, 0, '0);
    chk("pop1_q", 64'(sif.q), 64'h33);
    step("pop2", 0, 1, 0, '0);
    chk("pop2_q", 64'(sif.q), 64'h22);
    step("pop3", 0, 1, 0, '0);
    chk("pop3_q", 64'(sif.q), 64'h11);
    chk("pop3_empty", 64'(sif.empty), 64'd1);

    step("pushr", 1, 0, 0, $urandom);
    step("pushAA", 1, 0, 0, 32'hAA);
    step("held", 1, 1, 1, 32'h55);
    chk("held_sp", 64'(sif.sp), 64'd2);
    chk("held_q", 64'(sif.q), 64'h11);
    step("swap", 1, 1, 0, 32'h55);
    chk("swap_q", 64'(sif.q), 64'hAA);
    chk("swap_sp", 64'(sif.sp), 64'd2);
    step("popswap", 0, 1, 0, '0);
    chk("popswap_q", 64'(sif.q), 64'h55);
    step("popdrain", 0, 1, 0, '0);

    if (GUARD) begin
      for (int i = 0; i < DEPTH; i++) begin
        v_last = $urandom;
        step("fill", 1, 0, 0, v_last);
      end
      chk("fill_full", 64'(sif.full), 64'd1);
      step("ovf", 1, 0, 0, 32'hDEAD);
      chk("ovf_sp", 64'(sif.sp), 64'd128);
      chk("ovf_flag", 64'(sif.overflow), 64'd1);
      step("ovf_pop", 0, 1, 0, '0);
      chk("ovf_pop_q", 64'(sif.q), 64'(v_last));
      for (int i = 0; i < DEPTH - 1; i++) step("drain", 0, 1, 0, '0);
      step("udf", 0, 1, 0, '0);
      chk("udf_q", 64'(sif.q), 64'd0);
      chk("udf_flag", 64'(sif.underflow), 64'd1);
    end else begin
      for (int i = 1; i <= DEPTH + 1; i++) step("wrapfill", 1, 0, 0, DW'(i));
      chk("wrap_sp", 64'(sif.sp), 64'd1);
      chk("wrap_full", 64'(sif.full), 64'd0);
      step("wrap_pop", 0, 1, 0, '0);
      chk("wrap_pop_q", 64'(sif.q), 64'd129);
      step("wrap_pop0", 0, 1, 0, '0);
      chk("wrap_pop0_q", 64'(sif.q), 64'd128);
      chk("wrap_pop0_sp", 64'(sif.sp), 64'd127);
    end

    for (int i = 0; i < 300; i++) begin
      int r;
      r = int'($urandom_range(0, 9));
      step("rand", r < 5 || r == 9, (r >= 5 && r < 8) || r == 9, $urandom_range(0, 7) == 0, $urandom);
    end

    @(negedge clk);
    sif.push = 1'b1; sif.d = 32'h77;
    #2 reset = 1'b0;
    model_reset();
    #1;
    chk("async_sp", 64'(sif.sp), 64'd0);
    chk("async_q", 64'(sif.q), 64'd0);
    @(posedge clk);
    #1;
    sif.push = 1'b0;
    chk_all("in_reset");
    @(negedge clk);
    reset = 1'b1;
    step("post_reset_pop", 0, 1, 0, '0);
    if (GUARD) begin
      chk("post_reset_udf", 64'(sif.underflow), 64'd1);
      chk("post_reset_q", 64'(sif.q), 64'd0);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/stack_unit.md
Name: stack_unit

Overview:
- Hardware LIFO call/data stack in the CPU execute/memory stage.
- Consumes the push/pop strobes issued by the control unit.
  - PUSH stores the source-register value.
  - POP returns the top entry for register write-back.
- Provides stack status to the pipeline and to debug logic.

Parameters:
- DATA_W, 32, width of each stack entry
- DEPTH, 128, number of entries; must be a power of two
- ADDR_W, 7, log2(DEPTH)

Ports:
- clk  input  1  system clock; all state on rising edge
- reset  input  1  asynchronous, active-low reset
- push  input  1  push strobe from control unit
- pop  input  1  pop strobe from control unit
- hold  input  1  pipeline stall; push/pop ignored while high
- d  input  DATA_W  data to push
- q  output  DATA_W  registered popped data
- sp  output  ADDR_W+1  current entry count, 0..DEPTH
- empty  output  1  sp == 0
- full  output  1  sp == DEPTH
- overflow  output  1  sticky push-when-full error
- underflow  output  1  sticky pop-when-empty error

Behaviour:
- One clock domain. Reset is asynchronous and active-low.
- While reset is low:
  - sp=0, q=0, empty=1, full=0, overflow=0, underflow=0.
  - Storage array is not reset; its contents are don't-care.
- Reset asserted mid-operation aborts the in-flight push/pop with no memory write.
- Effective strobes: push_e = push & ~hold; pop_e = pop & ~hold.
- Storage: DEPTH x DATA_W register array (or LUT RAM), written synchronously.
- Push only (push_e & ~pop_e):
  - mem[sp[ADDR_W-1:0]] <= d; sp <= sp+1.
  - q holds its value.
- Pop only (pop_e & ~push_e):
  - q <= mem[sp-1]; sp <= sp-1.
  - q is valid the cycle after the pop strobe (latency 1). Write-back samples q one cycle later.
- Push and pop together (swap):
  - q <= mem[sp-1]; mem[sp-1] <= d; sp unchanged.
  - If empty: q <= d, no write, sp unchanged.
- Neither strobe, or hold=1: no state change; q holds.
- Pop in the cycle directly after a push returns the just-pushed value (no read-after-write hazard, same array).
- empty/full are combinational decodes of sp, so they update the same cycle sp changes.
- Boundary conditions: see Optional Feature.

Optional Feature:
- Macro: STACK_GUARD_EN.
- Defined:
  - Push with full=1: no write, sp unchanged, overflow <= 1.
  - Pop with empty=1: q <= 0, sp unchanged, underflow <= 1.
  - Swap is never an error.
  - overflow and underflow stay set until reset.
- Undefined:
  - sp is a modulo-DEPTH counter; sp[ADDR_W] is tied 0.
  - full is tied 0; overflow and underflow are tied 0.
  - Push at sp=DEPTH-1 writes mem[DEPTH-1], and sp wraps to 0.
  - Pop at sp=0 returns mem[DEPTH-1], and sp becomes DEPTH-1.

Test Plan:
- Reset low for 3 cycles, then release -> sp=0, empty=1, q=0, overflow=0, underflow=0.
- Push 0x11, 0x22, 0x33 on consecutive cycles, then pop x3 -> q=0x33, 0x22, 0x11 one cycle after each pop; sp goes 3,2,1,0; empty=1 at end.
- sp=2 with top=0xAA; push=1 and pop=1 with hold=1 -> sp stays 2, q unchanged; drop hold -> swap: q=0xAA, top becomes d=0x55, sp=2; next pop -> q=0x55.
- With STACK_GUARD_EN:
  - Push 128 values -> full=1.
  - 129th push of 0xDEAD -> sp=128, overflow=1.
  - Pop -> q=value #128, not 0xDEAD.
  - Pop at empty -> q=0, underflow=1.
- Without STACK_GUARD_EN:
  - Push 129 values 1..129 -> sp=1, full=0.
  - Pop -> q=129.
  - Pop at sp=0 -> q=128, sp=127.
- Push 0x77 and drive reset low asynchronously mid-cycle before the next edge -> sp=0, q=0 immediately; after release, pop -> underflow=1 (guard on) and q=0.
